// File: rtl/uart_tx_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx_stream
// Purpose  : Stream-fed UART transmitter. Bytes arrive over a valid/ready
//            handshake, are buffered in a small FIFO and serialised 8N1
//            (LSB first) on the tx line. It is the output-side counterpart of
//            the board's UART receiver and uses the same clock, baud and
//            oversample settings.
// Options  : UART_TX_PARITY_EN - when defined, a parity bit (even by default,
//            odd with PARITY_ODD=1) is inserted after the data bits.
// Ports    : clk        in   board clock
//            rst        in   asynchronous active-high reset
//            tx_data    in   [7:0] byte to send
//            tx_valid   in   tx_data valid
//            tx_ready   out  FIFO can accept (not full)
//            tx         out  serial line, idle high, registered
//            tx_busy    out  frame on the line or FIFO non-empty
//            fifo_count out  FIFO occupancy, 0..FIFO_DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_stream #(
  parameter int CLOCK_RATE      = 10000000,
  parameter int BAUD_RATE       = 625000,
  parameter int OVERSAMPLE_RATE = 16,
  parameter int DIVISOR         = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE_RATE),
  parameter int FIFO_DEPTH      = 4,
  parameter int STOP_BITS       = 1
`ifdef UART_TX_PARITY_EN
  ,
  parameter bit PARITY_ODD      = 1'b0
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam int c_div_w = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int c_os_w  = (OVERSAMPLE_RATE > 1) ? $clog2(OVERSAMPLE_RATE) : 1;

  localparam logic [c_div_w-1:0] c_div_max   = c_div_w'(DIVISOR - 1);
  localparam logic [c_os_w-1:0]  c_os_max    = c_os_w'(OVERSAMPLE_RATE - 1);
  localparam logic [c_cnt_w-1:0] c_full      = c_cnt_w'(FIFO_DEPTH);
  localparam logic               c_stop_last = 1'(STOP_BITS - 1);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    ,
    S_PARITY = 3'd4
`endif
  } state_t;

  // --------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // --------------------------------------------------------------------------
  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_ptr_w-1:0]  r_rd_ptr;
  logic [c_cnt_w-1:0]  r_count;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;

  // --------------------------------------------------------------------------
  // Transmit engine
  // --------------------------------------------------------------------------
  state_t              r_state;
  logic [c_div_w-1:0]  r_div;
  logic [c_os_w-1:0]   r_tick_cnt;
  logic [7:0]          r_shift;
  logic [2:0]          r_bit_idx;
  logic                r_stop_cnt;
  logic                r_tx;
`ifdef UART_TX_PARITY_EN
  logic                r_parity;
`endif

  logic                w_tick;
  logic                w_bit_end;
  logic                w_last_stop;

  assign w_full  = (r_count == c_full);
  assign w_empty = (r_count == '0);
  assign w_push  = tx_valid && !w_full;

  // The divider only runs while a frame is in progress, so the first tick of
  // every frame lands a full DIVISOR clocks after the pop.
  assign w_tick      = (r_state != S_IDLE) && (r_div == c_div_max);
  assign w_bit_end   = w_tick && (r_tick_cnt == c_os_max);
  assign w_last_stop = (r_state == S_STOP) && w_bit_end && (r_stop_cnt == c_stop_last);

  // A byte leaves the FIFO either from IDLE or at the very end of the last
  // stop bit, which lets consecutive frames run without an idle gap.
  assign w_pop = !w_empty && ((r_state == S_IDLE) || w_last_stop);

  // --------------------------------------------------------------------------
  // FIFO memory (no reset needed: contents are only read when counted valid)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_data;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Depth is a power of two, so natural pointer overflow is the wrap.
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Baud divider and oversample tick counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div      <= '0;
      r_tick_cnt <= '0;
    end else if (w_pop || (r_state == S_IDLE)) begin
      // Restart timing at every frame start; hold at zero while idle.
      r_div      <= '0;
      r_tick_cnt <= '0;
    end else begin
      if (w_tick) begin
        r_div <= '0;
        if (r_tick_cnt == c_os_max) begin
          r_tick_cnt <= '0;
        end else begin
          r_tick_cnt <= r_tick_cnt + c_os_w'(1);
        end
      end else begin
        r_div <= r_div + c_div_w'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame state machine with registered line output
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_tx       <= 1'b1;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
`ifdef UART_TX_PARITY_EN
            r_parity <= (^r_mem[r_rd_ptr]) ^ PARITY_ODD;
`endif
            r_state <= S_START;
            r_tx    <= 1'b0;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_state   <= S_DATA;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_state <= S_PARITY;
              r_tx    <= r_parity;
`else
              r_state    <= S_STOP;
              r_tx       <= 1'b1;
              r_stop_cnt <= 1'b0;
`endif
            end else begin
              // Present the next bit directly so tx stays registered.
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_state    <= S_STOP;
            r_tx       <= 1'b1;
            r_stop_cnt <= 1'b0;
          end
        end
`endif

        S_STOP: begin
          if (w_bit_end) begin
            if (r_stop_cnt == c_stop_last) begin
              if (w_pop) begin
                r_shift <= r_mem[r_rd_ptr];
`ifdef UART_TX_PARITY_EN
                r_parity <= (^r_mem[r_rd_ptr]) ^ PARITY_ODD;
`endif
                r_state <= S_START;
                r_tx    <= 1'b0;
              end else begin
                r_state <= S_IDLE;
                r_tx    <= 1'b1;
              end
            end else begin
              r_stop_cnt <= r_stop_cnt + 1'b1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign tx         = r_tx;
  assign tx_ready   = !w_full;
  assign tx_busy    = (r_state != S_IDLE) || !w_empty;
  assign fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_stream
// Purpose  : Directed self-checking bench for uart_tx_stream (default build
//            plus a DIVISOR=3 instance; parity frames when UART_TX_PARITY_EN
//            is defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic [2:0] fifo_count;

  logic [7:0] tx_data3 = 8'h00;
  logic       tx_valid3 = 1'b0;
  logic       tx_ready3;
  logic       tx3;
  logic       tx_busy3;
  logic [2:0] fifo_count3;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  uart_tx_stream dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count)
  );

  uart_tx_stream #(.CLOCK_RATE(30000000)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data3),
    .tx_valid   (tx_valid3),
    .tx_ready   (tx_ready3),
    .tx         (tx3),
    .tx_busy    (tx_busy3),
    .fifo_count (fifo_count3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function logic line_of(input bit sel);
    return sel ? tx3 : tx;
  endfunction

  // Wait (bounded) for the next negedge that sees the start bit.
  task automatic wait_start(input string tag, input bit sel, input int budget, output int waited);
    waited = 0;
    @(negedge clk);
    while ((line_of(sel) !== 1'b0) && (waited < budget)) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, " start"}, line_of(sel), 0);
  endtask

  // Called with the first start-bit sample already taken; checks every
  // remaining sample of the frame, one comparison per bit period.
  task automatic frame(input string tag, input logic [7:0] d, input int per, input bit sel);
    logic [10:0] bits;
    int nb;
    int bad;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
    bits[9]  = ^d;
    bits[10] = 1'b1;
    nb = 11;
`else
    bits[9] = 1'b1;
    nb = 10;
`endif
    for (int b = 0; b < nb; b++) begin
      bad = 0;
      for (int s = (b == 0) ? 1 : 0; s < per; s++) begin
        @(negedge clk);
        if (line_of(sel) !== bits[b]) bad++;
      end
      chk($sformatf("%s bit%0d bad samples", tag, b), bad, 0);
    end
  endtask

  int  k, n, w, bad;
  bit  acc, seen_full;

  initial begin
    // ---------------- reset ----------------
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset tx", tx, 1);
    chk("reset busy", tx_busy, 0);
    chk("reset count", fifo_count, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset ready", tx_ready, 1);
    chk("reset idle tx", tx, 1);

    // ---------------- single byte 0xA5 ----------------
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("a5 count after push", fifo_count, 1);
    chk("a5 tx before pop", tx, 1);
    @(negedge clk);
    chk("a5 start latency", tx, 0);
    chk("a5 popped count", fifo_count, 0);
    chk("a5 busy", tx_busy, 1);
    frame("a5", 8'hA5, 16, 1'b0);
    @(negedge clk);
    chk("a5 busy after frame", tx_busy, 0);
    chk("a5 idle tx", tx, 1);

    // ---------------- back-to-back 0x00, 0xFF ----------------
    tx_data = 8'h00; tx_valid = 1'b1;
    @(negedge clk);
    chk("b2b count first", fifo_count, 1);
    tx_data = 8'hFF;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("b2b count push+pop", fifo_count, 1);
    chk("b2b start 00", tx, 0);
    frame("b2b00", 8'h00, 16, 1'b0);
    @(negedge clk);
    chk("b2b contiguous start", tx, 0);
    chk("b2b count second pop", fifo_count, 0);
    frame("b2bff", 8'hFF, 16, 1'b0);
    @(negedge clk);
    chk("b2b busy after", tx_busy, 0);

    // ---------------- full FIFO, 6 bytes with valid held ----------------
    fork
      begin
        k = 1; n = 0; seen_full = 1'b0;
        tx_data = 8'd1; tx_valid = 1'b1;
        while ((k <= 6) && (n < 1000)) begin
          acc = tx_ready;
          @(negedge clk);
          n++;
          if (acc) begin
            k++;
            tx_data = 8'(k);
          end
          if ((fifo_count == 3'd4) && !seen_full) begin
            seen_full = 1'b1;
            chk("full ready low", tx_ready, 0);
            chk("full busy", tx_busy, 1);
          end
        end
        tx_valid = 1'b0;
        chk("full all accepted", k, 7);
        chk("full reached", seen_full, 1);
      end
      begin
        for (int i = 1; i <= 6; i++) begin
          wait_start($sformatf("full%0d", i), 1'b0, 400, w);
          if (i > 1) chk($sformatf("full%0d gap", i), w, 0);
          frame($sformatf("full%0d", i), 8'(i), 16, 1'b0);
        end
      end
    join
    @(negedge clk);
    chk("full busy after", tx_busy, 0);
    chk("full count after", fifo_count, 0);

    // ---------------- reset mid-frame ----------------
    tx_data = 8'h3C; tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'h99;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("rmf start", tx, 0);
    repeat (15 + 32 + 8) @(negedge clk);
    chk("rmf bit3 level", tx, 1);
    chk("rmf queued", fifo_count, 1);
    #2 rst = 1'b1;
    #1;
    chk("rmf async tx", tx, 1);
    chk("rmf async count", fifo_count, 0);
    chk("rmf async busy", tx_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if ((tx !== 1'b1) || (tx_busy !== 1'b0)) bad++;
    end
    chk("rmf quiet after reset", bad, 0);
    chk("rmf count after reset", fifo_count, 0);
    tx_data = 8'h81; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_start("r81", 1'b0, 4, w);
    chk("r81 latency", w, 0);
    frame("r81", 8'h81, 16, 1'b0);
    @(negedge clk);
    chk("r81 busy after", tx_busy, 0);

`ifdef UART_TX_PARITY_EN
    // ---------------- parity frames ----------------
    tx_data = 8'h07; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_start("p07", 1'b0, 4, w);
    frame("p07", 8'h07, 16, 1'b0);
    @(negedge clk);
    chk("p07 busy after", tx_busy, 0);
    tx_data = 8'h03; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_start("p03", 1'b0, 4, w);
    frame("p03", 8'h03, 16, 1'b0);
    @(negedge clk);
    chk("p03 busy after", tx_busy, 0);
`endif

    // ---------------- DIVISOR=3 instance ----------------
    chk("d3 idle", tx3, 1);
    tx_data3 = 8'h55; tx_valid3 = 1'b1;
    @(negedge clk);
    tx_valid3 = 1'b0;
    chk("d3 count", fifo_count3, 1);
    wait_start("d3", 1'b1, 4, w);
    chk("d3 latency", w, 0);
    frame("d3", 8'h55, 48, 1'b1);
    @(negedge clk);
    chk("d3 busy after", tx_busy3, 0);
    chk("d3 ready", tx_ready3, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
